// File: rtl/ps2_scan_receiver.sv
// Host-side PS/2 keyboard receiver: deserialises device-to-host frames and decodes
// make/break/E0 sequences into key pulses plus shift, caps-lock and Thai-toggle levels.
module ps2_scan_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_ext,
  output logic       shift,
  output logic       cap_lock,
  output logic       change_to_thai,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] C_EXT    = 8'hE0;
  localparam logic [7:0] C_BREAK  = 8'hF0;
  localparam logic [7:0] C_LSHIFT = 8'h12;
  localparam logic [7:0] C_RSHIFT = 8'h59;
  localparam logic [7:0] C_CAPS   = 8'h58;
  localparam logic [7:0] C_THAI   = 8'h0E;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: bit 1 = data pin, bit 0 = clock pin
  // ---------------------------------------------------------------------------
  logic [1:0] w_pin_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic       w_clk_s;
  logic       w_dat_s;

  assign w_pin_raw = {ps2_data, ps2_clk};
  assign w_clk_s   = r_sync2[0];
  assign w_dat_s   = r_sync2[1];

  // Synchroniser idles high, matching the open-collector bus idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= w_pin_raw;
      r_sync2 <= r_sync1;
    end
  end

  logic          r_filt_clk;
  logic          r_filt_d;
  logic [FW-1:0] r_filt_cnt;
  logic          w_fall;

  // Level flips only after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_clk <= 1'b0;
      r_filt_d   <= 1'b0;
      r_filt_cnt <= '0;
    end else begin
      r_filt_d <= r_filt_clk;
      if (w_clk_s != r_filt_clk) begin
        if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
          r_filt_clk <= w_clk_s;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_fall = r_filt_d & ~r_filt_clk;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          r_frame_err;
  logic          w_frame_ok;
  logic          w_byte_strobe;

  // Odd parity over data+parity, and stop bit must be high
  assign w_frame_ok    = w_dat_s & (^r_shift ^ r_parity);
  assign w_byte_strobe = w_fall & (r_state == S_STOP) & w_frame_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_to_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!w_dat_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_parity <= w_dat_s;
            r_state  <= S_STOP;
          end
          S_STOP: begin
            if (!w_frame_ok) begin
              r_frame_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          r_frame_err <= 1'b1;
          r_state     <= S_IDLE;
          r_to_cnt    <= '0;
          r_shift     <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Byte layer: make/break/extended decoding and modifier tracking
  // ---------------------------------------------------------------------------
  logic       r_ext_pend;
  logic       r_brk_pend;
  logic       r_lshift_held;
  logic       r_rshift_held;
  logic       r_caps_held;
  logic       r_thai_held;
  logic       r_cap_lock;
  logic       r_thai;
  logic [7:0] r_key_code;
  logic       r_key_ext;
  logic       r_key_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_pend    <= 1'b0;
      r_brk_pend    <= 1'b0;
      r_lshift_held <= 1'b0;
      r_rshift_held <= 1'b0;
      r_caps_held   <= 1'b0;
      r_thai_held   <= 1'b0;
      r_cap_lock    <= 1'b0;
      r_thai        <= 1'b0;
      r_key_code    <= '0;
      r_key_ext     <= 1'b0;
      r_key_valid   <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_byte_strobe) begin
        if (r_shift == C_EXT) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == C_BREAK) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
          if (r_brk_pend) begin
            if (!r_ext_pend && r_shift == C_LSHIFT) r_lshift_held <= 1'b0;
            if (!r_ext_pend && r_shift == C_RSHIFT) r_rshift_held <= 1'b0;
            if (r_shift == C_CAPS) r_caps_held <= 1'b0;
            if (r_shift == C_THAI) r_thai_held <= 1'b0;
          end else if (!r_ext_pend && r_shift == C_LSHIFT) begin
            r_lshift_held <= 1'b1;
          end else if (!r_ext_pend && r_shift == C_RSHIFT) begin
            r_rshift_held <= 1'b1;
          end else if (r_shift == C_CAPS) begin
            // Held latch stops typematic repeats from re-toggling
            if (!r_caps_held) r_cap_lock <= ~r_cap_lock;
            r_caps_held <= 1'b1;
          end else if (r_shift == C_THAI) begin
            if (!r_thai_held) r_thai <= ~r_thai;
            r_thai_held <= 1'b1;
          end else if (r_ext_pend && (r_shift == C_LSHIFT || r_shift == C_RSHIFT)) begin
            r_key_valid <= 1'b0;
          end else begin
            r_key_code  <= r_shift;
            r_key_ext   <= r_ext_pend;
            r_key_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign key_code       = r_key_code;
  assign key_valid      = r_key_valid;
  assign key_ext        = r_key_ext;
  assign shift          = r_lshift_held | r_rshift_held;
  assign cap_lock       = r_cap_lock;
  assign change_to_thai = r_thai;
  assign frame_err      = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: drives PS/2 frames bit by bit and checks
// emitted key pulses, modifier levels and frame error handling.
module tb_ps2_scan_receiver;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int HALF           = 20;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_ext;
  logic       shift;
  logic       cap_lock;
  logic       change_to_thai;
  logic       frame_err;

  int n_cmp;
  int n_err;
  int kv_total;
  int fe_total;
  int both_total;
  int kv0;
  int fe0;
  logic [7:0] last_code;
  logic       last_ext;

  ps2_scan_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .key_code       (key_code),
    .key_valid      (key_valid),
    .key_ext        (key_ext),
    .shift          (shift),
    .cap_lock       (cap_lock),
    .change_to_thai (change_to_thai),
    .frame_err      (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        kv_total  = kv_total + 1;
        last_code = key_code;
        last_ext  = key_ext;
      end
      if (frame_err) fe_total = fe_total + 1;
      if (key_valid && frame_err) both_total = both_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends the first nbits of a frame (11 = complete); bad_par inverts the parity bit
  task automatic ps2_send(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(posedge clk);
    ps2_data = 1'b1;
    repeat (HALF * 2) @(posedge clk);
    $display("frame 0x%02h bad_par=%0d bits=%0d : kv=%0d code=0x%02h ext=%0d fe=%0d shift=%0d caps=%0d thai=%0d",
             b, bad_par, nbits, kv_total, last_code, last_ext, fe_total, shift, cap_lock, change_to_thai);
  endtask

  task automatic frame(input logic [7:0] b);
    ps2_send(b, 1'b0, 11);
  endtask

  task automatic mark();
    kv0 = kv_total;
    fe0 = fe_total;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; kv_total = 0; fe_total = 0; both_total = 0;
    last_code = 8'h00; last_ext = 1'b0;
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_ext", key_ext, 0);
    chk("rst_shift", shift, 0);
    chk("rst_cap_lock", cap_lock, 0);
    chk("rst_thai", change_to_thai, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // Plain make code
    mark();
    frame(8'h1C);
    chk("1c_kv", kv_total - kv0, 1);
    chk("1c_code", last_code, 8'h1C);
    chk("1c_ext", last_ext, 0);
    chk("1c_fe", fe_total - fe0, 0);
    chk("1c_hold_code", key_code, 8'h1C);

    // Shift make/break around a key
    mark();
    frame(8'h12);
    chk("lshift_set", shift, 1);
    frame(8'h1C);
    chk("shifted_code", last_code, 8'h1C);
    frame(8'hF0); frame(8'h1C);
    chk("shift_still", shift, 1);
    frame(8'hF0); frame(8'h12);
    chk("lshift_clr", shift, 0);
    chk("shift_seq_kv", kv_total - kv0, 1);
    frame(8'h59);
    chk("rshift_set", shift, 1);
    frame(8'hF0); frame(8'h59);
    chk("rshift_clr", shift, 0);

    // Caps lock with typematic repeats
    mark();
    frame(8'h58);
    chk("caps_first", cap_lock, 1);
    frame(8'h58); frame(8'h58);
    chk("caps_repeat", cap_lock, 1);
    frame(8'hF0); frame(8'h58);
    chk("caps_after_brk", cap_lock, 1);
    frame(8'h58);
    chk("caps_second", cap_lock, 0);
    frame(8'hF0); frame(8'h58);
    chk("caps_kv", kv_total - kv0, 0);

    // Thai toggle, same rule
    mark();
    frame(8'h0E);
    chk("thai_first", change_to_thai, 1);
    frame(8'h0E); frame(8'h0E);
    chk("thai_repeat", change_to_thai, 1);
    frame(8'hF0); frame(8'h0E);
    frame(8'h0E);
    chk("thai_second", change_to_thai, 0);
    chk("thai_caps_kept", cap_lock, 0);
    chk("thai_kv", kv_total - kv0, 0);

    // Extended key and fake shift
    mark();
    frame(8'hE0); frame(8'h5A);
    chk("e0_kv", kv_total - kv0, 1);
    chk("e0_code", last_code, 8'h5A);
    chk("e0_ext", last_ext, 1);
    mark();
    frame(8'hE0); frame(8'h12);
    chk("fake_shift", shift, 0);
    chk("fake_shift_kv", kv_total - kv0, 0);
    frame(8'h1C);
    chk("ext_cleared", last_ext, 0);
    chk("ext_cleared_code", last_code, 8'h1C);

    // Parity error then recovery
    mark();
    ps2_send(8'h1C, 1'b1, 11);
    chk("par_fe", fe_total - fe0, 1);
    chk("par_kv", kv_total - kv0, 0);
    frame(8'h32);
    chk("par_recover_code", last_code, 8'h32);
    chk("par_recover_kv", kv_total - kv0, 1);

    // Timeout after start + 5 data bits
    mark();
    ps2_send(8'h24, 1'b0, 6);
    repeat (TIMEOUT_CYCLES + 200) @(posedge clk);
    chk("timeout_fe", fe_total - fe0, 1);
    chk("timeout_kv", kv_total - kv0, 0);
    frame(8'h24);
    chk("timeout_recover_code", last_code, 8'h24);
    chk("timeout_recover_kv", kv_total - kv0, 1);
    chk("timeout_recover_fe", fe_total - fe0, 1);

    // 2-cycle glitch low while data low must not start a frame
    mark();
    ps2_data = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(posedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    frame(8'h2B);
    chk("glitch_fe", fe_total - fe0, 0);
    chk("glitch_kv", kv_total - kv0, 1);
    chk("glitch_code", last_code, 8'h2B);

    // Reset mid-frame with shift held
    frame(8'h12);
    chk("pre_rst_shift", shift, 1);
    ps2_send(8'h44, 1'b0, 4);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_shift", shift, 0);
    chk("midrst_code", key_code, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    mark();
    frame(8'h1C);
    chk("post_rst_code", last_code, 8'h1C);
    chk("post_rst_kv", kv_total - kv0, 1);
    chk("post_rst_fe", fe_total - fe0, 0);

    chk("kv_fe_exclusive", both_total, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
